// File: rtl/tx_pkg.sv
// Shared types and default parameters for the tx_inf receive-side sink.
package tx_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_BODY,
    RX_DROP
  } rx_state_e;

  localparam int unsigned TX_DW      = 32;
  localparam int unsigned TX_DEPTH   = 16;
  localparam int unsigned TX_MAX_LEN = 64;

endpackage

// File: rtl/tx_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers and a registered head output
// (the head register is refreshed every cycle, with bypass when writing into an empty slot).
module tx_sync_fifo #(
  parameter int unsigned W     = 33,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               wdata,
  input  logic                       pop,
  output logic [W-1:0]               rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr, rptr, wptr_n, rptr_n;
  logic          push_ok, pop_ok;

  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty   = (wptr == rptr);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wptr_n = wptr + PW'(push_ok);
    rptr_n = rptr + PW'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[AW-1:0]] <= wdata;
  end

  // Head register tracks the next read slot; a write landing there is forwarded directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      rdata <= '0;
      level <= '0;
    end else begin
      wptr  <= wptr_n;
      rptr  <= rptr_n;
      level <= wptr_n - rptr_n;
      if (push_ok && (wptr[AW-1:0] == rptr_n[AW-1:0])) rdata <= wdata;
      else                                             rdata <= mem[rptr_n[AW-1:0]];
    end
  end

endmodule

// File: rtl/tx_rx_sink.sv
// Receive endpoint of the tx_inf handshake: buffers beats into a FIFO, truncates
// packets longer than MAX_LEN and counts packets written.
module tx_rx_sink
  import tx_pkg::*;
#(
  parameter int unsigned DW      = TX_DW,
  parameter int unsigned DEPTH   = TX_DEPTH,
  parameter int unsigned MAX_LEN = TX_MAX_LEN
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       async_en,
  output logic                       async_rdy,
  input  logic [DW-1:0]              tx_data,
  input  logic                       tx_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DW-1:0]              out_data,
  output logic                       out_last,
  output logic                       trunc_err,
  output logic [15:0]                pkt_cnt,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;
  localparam int unsigned BW = $clog2(MAX_LEN + 1);

  rx_state_e     state, state_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic [15:0]   pkt_n;
  logic [LW-1:0] level_n;
  logic          acc, push, pop, last_eff, trunc_c, rdy_n;
  logic          full, empty;

  assign acc       = async_en && async_rdy;
  assign push      = acc && (state != RX_DROP) && !full;
  assign pop       = out_valid && out_ready;
  assign out_valid = !empty;
  assign last_eff  = tx_last || (bcnt == BW'(MAX_LEN - 1));
  assign level_n   = level + LW'(push) - LW'(pop);

  tx_sync_fifo #(
    .W     (DW + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({last_eff, tx_data}),
    .pop   (pop),
    .rdata ({out_last, out_data}),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // Packet framing: a forced last beat without tx_last diverts to DROP until the real end.
  always_comb begin
    state_n = state;
    bcnt_n  = bcnt;
    pkt_n   = pkt_cnt;
    trunc_c = 1'b0;
    unique case (state)
      RX_IDLE, RX_BODY: begin
        if (acc) begin
          if (last_eff) begin
            bcnt_n = '0;
            pkt_n  = pkt_cnt + 16'd1;
            if (tx_last) begin
              state_n = RX_IDLE;
            end else begin
              state_n = RX_DROP;
              trunc_c = 1'b1;
            end
          end else begin
            bcnt_n  = bcnt + BW'(1);
            state_n = RX_BODY;
          end
        end
      end
      RX_DROP: begin
        if (acc && tx_last) state_n = RX_IDLE;
      end
      default: state_n = RX_IDLE;
    endcase
    // Ready is registered, so it is computed from next-cycle occupancy.
    rdy_n = (state_n == RX_DROP) || (level_n != LW'(DEPTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RX_IDLE;
      bcnt      <= '0;
      pkt_cnt   <= '0;
      trunc_err <= 1'b0;
      async_rdy <= 1'b0;
    end else begin
      state     <= state_n;
      bcnt      <= bcnt_n;
      pkt_cnt   <= pkt_n;
      trunc_err <= trunc_c;
      async_rdy <= rdy_n;
    end
  end

endmodule
